arb_rr_mutex: RTL and testbench



---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_rr_pick.sv | 42 ++++
 rtl/arb_rr_mutex.sv | 90 +++++++++
 tb/tb_arb_rr_mutex.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter family: width helper, default channel
// count and the owner-state encoding.
package arb_pkg;

    localparam int ARB_DEFAULT_N = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // ceil(log2(v)), never below 1 so every derived vector has at least one bit
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating priority encoder: first set request scanning start, start+1, ...
// modulo N, optionally skipping one excluded channel.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter  int N    = ARB_DEFAULT_N,
    localparam int ID_W = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    input  logic            excl_en,
    input  logic [ID_W-1:0] excl_id,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    localparam int NP = 1 << ID_W;

    logic [NP-1:0]   req_ext;
    logic [ID_W-1:0] pos_id;
    int              pos;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        found          = 1'b0;
        idx            = '0;
        pos            = 0;
        pos_id         = '0;
        for (int k = 0; k < N; k++) begin
            // start is always below N, so one subtraction completes the wrap
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            pos_id = ID_W'(pos);
            if (!found && req_ext[pos_id] && !(excl_en && (pos_id == excl_id))) begin
                found = 1'b1;
                idx   = pos_id;
            end
        end
    end

endmodule

// File: rtl/arb_rr_mutex.sv
// N-channel round-robin mutex arbiter with lock semantics and an optional
// hold limit that forces handover when other channels are waiting.
module arb_rr_mutex
    import arb_pkg::*;
#(
    parameter  int N        = ARB_DEFAULT_N,
    parameter  int MAX_HOLD = 0,
    localparam int ID_W     = clog2_min1(N),
    localparam int CNT_W    = clog2_min1(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            preempt
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N - 1);

    arb_state_e      state;
    logic [ID_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] win_next;
    logic            owner_req;
    logic            take;
    logic            force_ho;

    // ptr already equals owner+1, so one encoder serves both release and
    // forced handover; the owner is masked out while it holds the grant.
    arb_rr_pick #(.N(N)) u_pick (
        .req     (req),
        .start   (ptr),
        .excl_en (state == ST_OWNED),
        .excl_id (grant_id),
        .found   (found),
        .idx     (win)
    );

    assign grant_valid = |grant;
    assign owner_req   = |(req & grant);
    assign win_next    = (win == LAST_ID) ? '0 : win + ID_W'(1);

    always_comb begin
        take     = 1'b0;
        force_ho = 1'b0;
        if (state == ST_IDLE || !owner_req) begin
            take = found;
        end else if (MAX_HOLD > 0 && cnt == HOLD_LIM && found) begin
            take     = 1'b1;
            force_ho = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            cnt      <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (take) begin
                state    <= ST_OWNED;
                grant    <= N'(1) << win;
                grant_id <= win;
                ptr      <= win_next;
                cnt      <= CNT_ONE;
                preempt  <= force_ho;
            end else if (state == ST_OWNED && !owner_req) begin
                // released with nobody waiting: ptr keeps pointing past the old owner
                state    <= ST_IDLE;
                grant    <= '0;
                grant_id <= '0;
                cnt      <= '0;
            end else if (state == ST_OWNED && MAX_HOLD > 0 && cnt != HOLD_LIM) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_arb_rr_mutex.sv
// Bench for arb_rr_mutex: three configurations (N=3/MAX_HOLD=0, N=3/MAX_HOLD=4,
// N=5/MAX_HOLD=2) driven from one vector table plus a contended-hold sequence.
module tb_arb_rr_mutex;

    localparam int W = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [2:0] req_a, req_b;
    logic [4:0] req_c;
    logic [2:0] grant_a, grant_b;
    logic [4:0] grant_c;
    logic       gv_a, gv_b, gv_c;
    logic [1:0] id_a, id_b;
    logic [2:0] id_c;
    logic       pre_a, pre_b, pre_c;

    arb_rr_mutex #(.N(3), .MAX_HOLD(0)) u_a (
        .clk(clk), .rst_n(rst_a), .req(req_a), .grant(grant_a),
        .grant_valid(gv_a), .grant_id(id_a), .preempt(pre_a)
    );
    arb_rr_mutex #(.N(3), .MAX_HOLD(4)) u_b (
        .clk(clk), .rst_n(rst_b), .req(req_b), .grant(grant_b),
        .grant_valid(gv_b), .grant_id(id_b), .preempt(pre_b)
    );
    arb_rr_mutex #(.N(5), .MAX_HOLD(2)) u_c (
        .clk(clk), .rst_n(rst_c), .req(req_c), .grant(grant_c),
        .grant_valid(gv_c), .grant_id(id_c), .preempt(pre_c)
    );

    typedef struct {
        int         dut;
        logic       rst_n;
        logic [4:0] req;
        logic [4:0] grant;
        logic       pre;
        string      name;
    } vec_t;

    vec_t           vecs[$];
    logic [W-1:0]   exp_q[$];
    int             total = 0;
    int             bad = 0;
    bit             active = 1'b0;

    function automatic logic [2:0] gid(input logic [4:0] g);
        for (int i = 0; i < 5; i++) if (g[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [W-1:0] actual(input int d);
        case (d)
            0:       return {2'b00, grant_a, 1'b0, id_a, pre_a};
            1:       return {2'b00, grant_b, 1'b0, id_b, pre_b};
            default: return {grant_c, id_c, pre_c};
        endcase
    endfunction

    function automatic bit inv_ok(input logic [4:0] g, input logic v, input logic [2:0] id);
        if (!$onehot0(g)) return 1'b0;
        if (v !== |g) return 1'b0;
        if (v) return (id < 3'd5) && (g[id] === 1'b1);
        return id == 3'd0;
    endfunction

    task automatic add(input int d, input logic r, input logic [4:0] q,
                       input logic [4:0] g, input logic p, input string nm);
        vecs.push_back('{d, r, q, g, p, nm});
    endtask

    task automatic drive(input int d, input logic r, input logic [4:0] q,
                         input logic [4:0] g, input logic p);
        case (d)
            0:       begin rst_a = r; req_a = q[2:0]; end
            1:       begin rst_b = r; req_b = q[2:0]; end
            default: begin rst_c = r; req_c = q; end
        endcase
        exp_q.push_back({g, gid(g), p});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int d, input string nm);
        logic [W-1:0] e, a;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            a = actual(d);
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got grant=%b id=%0d pre=%b, need grant=%b id=%0d pre=%b",
                         nm, a[8:4], a[3:1], a[0], e[8:4], e[3:1], e[0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            total += 3;
            if (!inv_ok({2'b00, grant_a}, gv_a, {1'b0, id_a})) begin
                bad++;
                $display("FAIL inv_a: grant=%b valid=%b id=%0d", grant_a, gv_a, id_a);
            end
            if (!inv_ok({2'b00, grant_b}, gv_b, {1'b0, id_b})) begin
                bad++;
                $display("FAIL inv_b: grant=%b valid=%b id=%0d", grant_b, gv_b, id_b);
            end
            if (!inv_ok(grant_c, gv_c, id_c)) begin
                bad++;
                $display("FAIL inv_c: grant=%b valid=%b id=%0d", grant_c, gv_c, id_c);
            end
        end
    end

    initial begin
        int owner;
        logic p;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a = '0;   req_b = '0;   req_c = '0;
        repeat (3) step();
        active = 1'b1;

        // N=3, MAX_HOLD=0: reset, first grant, lock, release handover, no latching
        for (int i = 0; i < 3; i++) add(0, 0, 5'b00000, 5'b00000, 0, "a_reset");
        add(0, 1, 5'b00010, 5'b00010, 0, "a_first");
        add(0, 1, 5'b00011, 5'b00010, 0, "a_lock_011");
        for (int i = 0; i < 5; i++) add(0, 1, 5'b00111, 5'b00010, 0, "a_lock_111");
        add(0, 1, 5'b00101, 5'b00100, 0, "a_rel_ptr2");
        add(0, 1, 5'b00001, 5'b00001, 0, "a_rel_ch0");
        add(0, 1, 5'b00011, 5'b00001, 0, "a_pulse_on");
        add(0, 1, 5'b00001, 5'b00001, 0, "a_pulse_off");
        add(0, 1, 5'b00000, 5'b00000, 0, "a_idle");
        add(0, 1, 5'b00101, 5'b00100, 0, "a_ptr_kept");
        // rotation from ptr=0
        add(0, 0, 5'b00000, 5'b00000, 0, "a_rot_reset");
        add(0, 1, 5'b00111, 5'b00001, 0, "a_rot_0");
        add(0, 1, 5'b00110, 5'b00010, 0, "a_rot_1");
        add(0, 1, 5'b00111, 5'b00010, 0, "a_rot_1h");
        add(0, 1, 5'b00101, 5'b00100, 0, "a_rot_2");
        add(0, 1, 5'b00111, 5'b00100, 0, "a_rot_2h");
        add(0, 1, 5'b00011, 5'b00001, 0, "a_rot_wrap");
        add(0, 1, 5'b00111, 5'b00001, 0, "a_rot_0h");
        // reset mid-grant
        add(0, 0, 5'b00000, 5'b00000, 0, "a_mr_reset");
        add(0, 1, 5'b00010, 5'b00010, 0, "a_mr_grant");
        add(0, 0, 5'b00010, 5'b00000, 0, "a_mr_drop");
        add(0, 1, 5'b00011, 5'b00001, 0, "a_mr_ch0");
        // N=3, MAX_HOLD=4: uncontended owner, then late requester
        add(1, 0, 5'b00000, 5'b00000, 0, "b_reset");
        for (int i = 0; i < 10; i++) add(1, 1, 5'b00100, 5'b00100, 0, "b_alone");
        add(1, 1, 5'b00101, 5'b00001, 1, "b_late_pre");
        add(1, 1, 5'b00101, 5'b00001, 0, "b_late_hold");
        // N=5, MAX_HOLD=2: rotation with 4->0 wrap, then forced handover
        add(2, 0, 5'b00000, 5'b00000, 0, "c_reset");
        add(2, 1, 5'b11111, 5'b00001, 0, "c_rot_0");
        add(2, 1, 5'b11110, 5'b00010, 0, "c_rot_1");
        add(2, 1, 5'b11111, 5'b00010, 0, "c_rot_1h");
        add(2, 1, 5'b11101, 5'b00100, 0, "c_rot_2");
        add(2, 1, 5'b11111, 5'b00100, 0, "c_rot_2h");
        add(2, 1, 5'b11011, 5'b01000, 0, "c_rot_3");
        add(2, 1, 5'b11111, 5'b01000, 0, "c_rot_3h");
        add(2, 1, 5'b10111, 5'b10000, 0, "c_rot_4");
        add(2, 1, 5'b11111, 5'b10000, 0, "c_rot_4h");
        add(2, 1, 5'b01111, 5'b00001, 0, "c_wrap_0");
        add(2, 1, 5'b11111, 5'b00001, 0, "c_hold2");
        add(2, 1, 5'b11111, 5'b00010, 1, "c_force");

        foreach (vecs[i]) begin
            drive(vecs[i].dut, vecs[i].rst_n, vecs[i].req, vecs[i].grant, vecs[i].pre);
            step();
            check(vecs[i].dut, vecs[i].name);
        end

        // N=3, MAX_HOLD=4 contended: each owner exactly 4 cycles, order 0,1,2,0
        drive(1, 0, 5'b00000, 5'b00000, 0);
        step();
        check(1, "b_cont_reset");
        for (int c = 0; c < 16; c++) begin
            owner = (c / 4) % 3;
            p = (c % 4 == 0) && (c > 0);
            drive(1, 1, 5'b00111, 5'(1 << owner), p);
            step();
            check(1, $sformatf("b_cont_%0d", c));
        end

        active = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
